// File: rtl/ddc_ctrl_pkg.sv
// Shared types and code-mapping helpers for the DLL delay-chain controller.
package ddc_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_e;
    typedef enum logic [1:0] {NONE, UP, DN} dir_e;

    // Widest chain the helpers cover; callers use the low N_CELLS bits.
    localparam int MAX_CELLS = 64;

    function automatic logic [MAX_CELLS-1:0] thermo(input int unsigned p);
        logic [MAX_CELLS-1:0] r;
        for (int i = 0; i < MAX_CELLS; i++) r[i] = (i < p);
        return r;
    endfunction

    function automatic logic [MAX_CELLS-1:0] onehot(input int unsigned p);
        logic [MAX_CELLS-1:0] r;
        for (int i = 0; i < MAX_CELLS; i++) r[i] = (i == p);
        return r;
    endfunction

endpackage

// File: rtl/ddc_code_map.sv
// Turn-back position to per-cell forward (thermometer) and turn-back (one-hot) controls.
module ddc_code_map #(
    parameter  int N_CELLS = 32,
    localparam int PW      = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
    input  logic [PW-1:0]      i_pos,
    output logic [N_CELLS-1:0] o_t_code,
    output logic [N_CELLS-1:0] o_tb_code
);

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        assign o_t_code[i]  = (i_pos > PW'(i));
        assign o_tb_code[i] = (i_pos == PW'(i));
    end

endmodule

// File: rtl/ddc_chain_ctrl.sv
// DLL loop controller: filters phase-detector decisions, moves the chain turn-back
// point and reports lock / end-of-range.
module ddc_chain_ctrl
    import ddc_ctrl_pkg::*;
#(
    parameter  int N_CELLS  = 32,
    parameter  int INIT_POS = 0,
    parameter  int FILT_TH  = 4,
    parameter  int LOCK_CNT = 6,
    localparam int PW       = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               pd_valid,
    input  logic               pd_up,
    input  logic               pd_dn,
    output logic [N_CELLS-1:0] t_code,
    output logic [N_CELLS-1:0] tb_code,
    output logic [PW-1:0]      pos,
    output logic               lock,
    output logic               at_min,
    output logic               at_max
);

    state_e             r_state, w_state_nxt;
    dir_e               r_last, w_dir;
    logic signed [5:0]  r_acc, w_inc, w_acc_sum, w_th;
    logic [PW-1:0]      r_pos;
    logic [3:0]         r_rev, w_rev_nxt;
    logic               r_lock;
    logic               w_active, w_up, w_dn, w_step_up, w_step_dn, w_step, w_rev_flag;

    // Only a clean single-direction strobe is a decision.
    assign w_up      = pd_valid & pd_up & ~pd_dn;
    assign w_dn      = pd_valid & pd_dn & ~pd_up;
    assign w_inc     = w_up ? 6'sd1 : (w_dn ? -6'sd1 : 6'sd0);
    assign w_acc_sum = r_acc + w_inc;

    assign w_step_up  = w_active & w_up & (w_acc_sum == w_th);
    assign w_step_dn  = w_active & w_dn & (w_acc_sum == -w_th);
    assign w_step     = w_step_up | w_step_dn;
    assign w_dir      = w_step_up ? UP : DN;
    assign w_rev_flag = w_step & (r_last != NONE) & (r_last != w_dir);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = ACQ;
                ACQ:     if (w_rev_flag) w_state_nxt = TRACK;
                TRACK:   w_state_nxt = TRACK;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_active = en && (r_state != IDLE);
        w_th     = (r_state == TRACK) ? 6'(FILT_TH) : 6'sd1;
    end

    // Reversal counter only moves on TRACK steps; same-direction steps restart it.
    always_comb begin
        w_rev_nxt = r_rev;
        if (r_state == TRACK && w_step) begin
            if (!w_rev_flag)                   w_rev_nxt = '0;
            else if (r_rev != 4'(LOCK_CNT))    w_rev_nxt = r_rev + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos  <= PW'(INIT_POS);
            r_acc  <= '0;
            r_rev  <= '0;
            r_last <= NONE;
            r_lock <= 1'b0;
        end else if (!en) begin
            r_acc  <= '0;
            r_rev  <= '0;
            r_last <= NONE;
            r_lock <= 1'b0;
        end else if (w_step) begin
            r_acc  <= '0;
            if (w_step_up && r_pos != PW'(N_CELLS-1)) r_pos <= r_pos + PW'(1);
            if (w_step_dn && r_pos != '0)             r_pos <= r_pos - PW'(1);
            r_last <= w_dir;
            r_rev  <= w_rev_nxt;
            if (r_state == TRACK) r_lock <= (w_rev_nxt == 4'(LOCK_CNT));
        end else if (w_active && (w_up || w_dn)) begin
            r_acc <= w_acc_sum;
        end
    end

    ddc_code_map #(.N_CELLS(N_CELLS)) u_map (
        .i_pos     (r_pos),
        .o_t_code  (t_code),
        .o_tb_code (tb_code)
    );

    assign pos    = r_pos;
    assign lock   = r_lock;
    assign at_min = (r_pos == '0);
    assign at_max = (r_pos == PW'(N_CELLS-1));

endmodule
